// File: rtl/set_cmd_scheduler_pkg.sv
// Shared types for the SET command scheduler: FSM states, the command bundle
// handed to the SET engine, set-mode encodings and the round-robin index helper.
// No ports; imported by the scheduler interface, arbiter and top.
package set_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [23:0] central;  // {x1,y1,x2,y2,x3,y3}
    logic [11:0] radius;   // {r1,r2,r3}
    logic [1:0]  mode;
  } set_cmd_t;

  localparam logic [1:0] MODE_A   = 2'b00;
  localparam logic [1:0] MODE_AND = 2'b01;
  localparam logic [1:0] MODE_OR  = 2'b10;
  localparam logic [1:0] MODE_XOR = 2'b11;

  // Slot reached by stepping 'off' places from 'base' around a ring of n.
  function automatic int rr_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/set_cmd_scheduler_if.sv
// Bundle of every non-clock signal of the SET command scheduler.
// Requester side: req_valid/req_ready/req_central/req_radius/req_mode (NREQ lanes).
// Engine side: set_en/set_central/set_radius/set_mode out, set_valid/set_candidate in.
// Response side: rsp_valid/rsp_ready/rsp_id/rsp_candidate/rsp_err.
// slave = scheduler view, master = environment (requesters + engine + response sink).
interface set_cmd_scheduler_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*24-1:0] req_central;
  logic [NREQ*12-1:0] req_radius;
  logic [NREQ*2-1:0]  req_mode;

  logic               set_en;
  logic [23:0]        set_central;
  logic [11:0]        set_radius;
  logic [1:0]         set_mode;
  logic               set_valid;
  logic [7:0]         set_candidate;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [7:0]         rsp_candidate;
  logic               rsp_err;

  modport slave (
    input  req_valid, req_central, req_radius, req_mode,
    input  set_valid, set_candidate, rsp_ready,
    output req_ready, set_en, set_central, set_radius, set_mode,
    output rsp_valid, rsp_id, rsp_candidate, rsp_err
  );

  modport master (
    output req_valid, req_central, req_radius, req_mode,
    output set_valid, set_candidate, rsp_ready,
    input  req_ready, set_en, set_central, set_radius, set_mode,
    input  rsp_valid, rsp_id, rsp_candidate, rsp_err
  );
endinterface

// File: rtl/set_cmd_scheduler_rr_arbiter.sv
// Round-robin picker: first set bit of i_req at or after i_ptr, wrapping modulo NREQ.
// Ports: i_req (request vector), i_ptr (highest-priority slot) -> o_gnt (one-hot),
//        o_idx (binary index of o_gnt), o_any (some request present). Purely combinational.
module set_rr_arbiter
  import set_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  logic [IDW-1:0] w_slot [NREQ];

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      w_slot[k] = IDW'(rr_idx(int'(i_ptr), k, NREQ));
    end
  end

  // Walk from the farthest slot back toward i_ptr so the nearest request wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req[w_slot[k]]) begin
        o_gnt            = '0;
        o_gnt[w_slot[k]] = 1'b1;
        o_idx            = w_slot[k];
        o_any            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/set_cmd_scheduler.sv
// Shares one SET circle-count engine among NREQ requesters: round-robin grant, 1-cycle
// set_en launch, wait for engine set_valid, return the candidate tagged with the requester id.
// Ports: clk, rst (async, active-high), bus (set_cmd_scheduler_if.slave: requesters, engine, response).
// Option macro SET_SCHED_TIMEOUT_EN: abandon WAIT after TIMEOUT cycles with rsp_err=1.
module set_cmd_scheduler
  import set_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
`ifdef SET_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input logic                clk,
  input logic                rst,
  set_cmd_scheduler_if.slave bus
);

  state_t         r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  set_cmd_t       r_cmd;
  logic           r_set_en;
  logic           r_rsp_vld;
  logic [IDW-1:0] r_rsp_id;
  logic [7:0]     r_rsp_cand;

  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_idx;
  logic [IDW-1:0]  w_ptr_nxt;
  logic            w_any;
  set_cmd_t        w_sel_cmd;

`ifdef SET_SCHED_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] r_tmo_cnt;
  logic       r_rsp_err;
`endif

  set_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Only IDLE accepts, so a grant is always a handshake (gnt implies that req_valid is set).
  assign bus.req_ready = (r_state == IDLE) ? w_gnt : '0;
  assign w_ptr_nxt     = IDW'(rr_idx(int'(w_idx), 1, NREQ));

  always_comb begin
    w_sel_cmd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_cmd.central = bus.req_central[24*i +: 24];
        w_sel_cmd.radius  = bus.req_radius[12*i +: 12];
        w_sel_cmd.mode    = bus.req_mode[2*i +: 2];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_id       <= '0;
      r_cmd      <= '0;
      r_set_en   <= 1'b0;
      r_rsp_vld  <= 1'b0;
      r_rsp_id   <= '0;
      r_rsp_cand <= '0;
`ifdef SET_SCHED_TIMEOUT_EN
      r_tmo_cnt  <= '0;
      r_rsp_err  <= 1'b0;
`endif
    end else begin
      r_set_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_cmd    <= w_sel_cmd;
            r_id     <= w_idx;
            r_ptr    <= w_ptr_nxt;
            r_set_en <= 1'b1;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          r_state <= WAIT;
`ifdef SET_SCHED_TIMEOUT_EN
          r_tmo_cnt <= '0;
`endif
        end
        WAIT: begin
          if (bus.set_valid) begin
            r_rsp_cand <= bus.set_candidate;
            r_rsp_id   <= r_id;
            r_rsp_vld  <= 1'b1;
            r_state    <= RESP;
`ifdef SET_SCHED_TIMEOUT_EN
            r_rsp_err  <= 1'b0;
          end else if (r_tmo_cnt == TMO_LAST) begin
            // Engine gave up on: report an empty candidate flagged as error.
            r_rsp_cand <= '0;
            r_rsp_id   <= r_id;
            r_rsp_err  <= 1'b1;
            r_rsp_vld  <= 1'b1;
            r_state    <= RESP;
          end else begin
            r_tmo_cnt  <= r_tmo_cnt + 8'd1;
`endif
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_vld <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.set_en        = r_set_en;
  assign bus.set_central   = r_cmd.central;
  assign bus.set_radius    = r_cmd.radius;
  assign bus.set_mode      = r_cmd.mode;
  assign bus.rsp_valid     = r_rsp_vld;
  assign bus.rsp_id        = r_rsp_id;
  assign bus.rsp_candidate = r_rsp_cand;
`ifdef SET_SCHED_TIMEOUT_EN
  assign bus.rsp_err       = r_rsp_err;
`else
  assign bus.rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_set_cmd_scheduler.sv
// Bench for set_cmd_scheduler: directed scenarios then randomized traffic, checked each
// cycle against a transaction-level model (round-robin winner, launch/response timing).
// Honours SET_SCHED_TIMEOUT_EN (runs the timeout scenario with TIMEOUT=10).
module tb_set_cmd_scheduler;
  import set_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
`ifdef SET_SCHED_TIMEOUT_EN
  localparam int TMO  = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  set_cmd_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  set_cmd_scheduler #(
    .NREQ(NREQ), .IDW(IDW)
`ifdef SET_SCHED_TIMEOUT_EN
    , .TIMEOUT(TMO)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc   = 0;
  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // stimulus controls
  logic [NREQ-1:0]    st_valid = '0;
  logic [NREQ*24-1:0] st_central = '0;
  logic [NREQ*12-1:0] st_radius = '0;
  logic [NREQ*2-1:0]  st_mode = '0;
  bit st_rsp_ready = 1'b1;
  bit st_rst       = 1'b1;
  int eng_delay    = -1;   // -1: random engine latency
  int eng_cand     = -1;   // -1: random candidate
  bit eng_never    = 1'b0;
  bit spur_en      = 1'b0;
  bit force_spur   = 1'b0;

  // reference model (transaction level)
  bit         busy = 1'b0;
  bit         sv_done = 1'b0;
  int         m_ptr = 0, m_id = 0;
  int         hs_cyc = -10, fire_cyc = -1, sv_cyc = -10;
  logic [23:0] m_c;
  logic [11:0] m_r;
  logic [1:0]  m_m;
  logic [7:0]  m_cand;
  bit          m_err;
  int n_grant = 0, n_rsp = 0, n_abort = 0, n_en = 0, n_err_obs = 0;
  int gnt_log[$];

  task automatic set_req(input int i, input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    st_central[24*i +: 24] = c;
    st_radius[12*i +: 12]  = r;
    st_mode[2*i +: 2]      = m;
  endtask

  task automatic step();
    logic            sv;
    logic [7:0]      svc;
    logic [NREQ-1:0] exp_rdy;
    bit              exp_rv;
    int              pick;
    @(negedge clk);
    rst              = st_rst;
    bus.req_valid    = st_rst ? '0 : st_valid;
    bus.req_central  = st_central;
    bus.req_radius   = st_radius;
    bus.req_mode     = st_mode;
    bus.rsp_ready    = st_rsp_ready;
    sv  = 1'b0;
    svc = 8'($urandom);
    if (busy && !sv_done && cyc == fire_cyc) begin
      sv = 1'b1;
      if (eng_cand >= 0) svc = 8'(eng_cand);
    end else if (!(busy && !sv_done && cyc > hs_cyc + 1) &&
                 (force_spur || (spur_en && $urandom_range(0, 7) == 0))) begin
      sv = 1'b1;  // stray strobe while the engine is not expected to answer
    end
    bus.set_valid     = sv;
    bus.set_candidate = svc;
    #1;
    if (bus.set_en) n_en++;
    if (st_rst) begin
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      chk("rst_set_en", 32'(bus.set_en), 0);
      chk("rst_set_central", 32'(bus.set_central), 0);
      chk("rst_set_radius", 32'(bus.set_radius), 0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 0);
      chk("rst_rsp_cand", 32'(bus.rsp_candidate), 0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 0);
      if (busy) n_abort++;
      busy = 1'b0; sv_done = 1'b0; m_ptr = 0;
    end else begin
      pick = -1;
      if (!busy) begin
        for (int k = 0; k < NREQ; k++) begin
          if (pick < 0 && st_valid[(m_ptr + k) % NREQ]) pick = (m_ptr + k) % NREQ;
        end
      end
      exp_rdy = '0;
      if (pick >= 0) exp_rdy[pick] = 1'b1;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("set_en", 32'(bus.set_en), 32'(busy && cyc == hs_cyc + 1));
      if (busy && cyc > hs_cyc) begin
        chk("set_central", 32'(bus.set_central), 32'(m_c));
        chk("set_radius", 32'(bus.set_radius), 32'(m_r));
        chk("set_mode", 32'(bus.set_mode), 32'(m_m));
      end
      exp_rv = busy && sv_done && cyc > sv_cyc;
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
      if (exp_rv) begin
        chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
        chk("rsp_cand", 32'(bus.rsp_candidate), 32'(m_cand));
        chk("rsp_err", 32'(bus.rsp_err), 32'(m_err));
        if (bus.rsp_err) n_err_obs++;
      end
      // what the coming clock edge does
      if (busy && !sv_done) begin
        if (sv && cyc == fire_cyc) begin
          sv_done = 1'b1; sv_cyc = cyc; m_cand = svc; m_err = 1'b0;
        end
`ifdef SET_SCHED_TIMEOUT_EN
        else if (cyc == hs_cyc + 1 + TMO) begin
          sv_done = 1'b1; sv_cyc = cyc; m_cand = '0; m_err = 1'b1;
        end
`endif
      end else if (exp_rv && st_rsp_ready) begin
        busy = 1'b0;
        n_rsp++;
      end
      if (pick >= 0) begin
        busy    = 1'b1;
        sv_done = 1'b0;
        hs_cyc  = cyc;
        m_id    = pick;
        m_c     = st_central[24*pick +: 24];
        m_r     = st_radius[12*pick +: 12];
        m_m     = st_mode[2*pick +: 2];
        m_ptr   = (pick + 1) % NREQ;
        if (eng_never)           fire_cyc = -1;
        else if (eng_delay >= 0) fire_cyc = cyc + 1 + eng_delay;
        else                     fire_cyc = cyc + 1 + $urandom_range(1, 5);
        n_grant++;
        gnt_log.push_back(pick);
      end
    end
    cyc++;
  endtask

  task automatic run_until_idle(input int lim, input string tag);
    int k = 0;
    while (busy && k < lim) begin
      step();
      k++;
    end
    chk(tag, 32'(busy), 0);
  endtask

  task automatic run_until_grants(input int n, input int lim, input string tag);
    int k = 0;
    while (gnt_log.size() < n && k < lim) begin
      step();
      k++;
    end
    chk(tag, 32'(gnt_log.size()), 32'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t2a[4];
    int t2b[2];
    int k;
    t2a = '{0, 1, 2, 3};
    t2b = '{0, 2};
    bus.req_valid = '0; bus.req_central = '0; bus.req_radius = '0; bus.req_mode = '0;
    bus.set_valid = 1'b0; bus.set_candidate = '0; bus.rsp_ready = 1'b0;
    repeat (2) step();
    st_rst = 1'b0;
    step();

    // single command, fixed engine answer 13
    set_req(0, 24'h440000, 12'h200, MODE_A);
    st_valid = 4'b0001; eng_delay = 3; eng_cand = 13; n_en = 0;
    step();
    st_valid = '0;
    run_until_idle(20, "t1_done");
    chk("t1_set_en_pulses", 32'(n_en), 1);
    chk("t1_rsp_count", 32'(n_rsp), 1);

    // reset while the engine is busy, then requester 1 served normally
    set_req(2, 24'h123456, 12'habc, MODE_XOR);
    st_valid = 4'b0100; eng_delay = 8; eng_cand = -1;
    step();
    st_valid = '0;
    repeat (3) step();
    st_rst = 1'b1;
    step();
    st_rst = 1'b0;
    set_req(1, 24'h0f0f0f, 12'h321, MODE_OR);
    st_valid = 4'b0010; eng_delay = -1;
    gnt_log.delete();
    step();
    st_valid = '0;
    run_until_idle(20, "t5_done");
    chk("t5_grant", 32'(gnt_log.size() > 0 ? gnt_log[0] : -1), 1);

    // round-robin order from ptr 0
    st_rst = 1'b1; step(); st_rst = 1'b0; step();
    for (int i = 0; i < NREQ; i++) set_req(i, 24'($urandom), 12'($urandom), 2'(i));
    gnt_log.delete();
    st_valid = 4'b1111;
    run_until_grants(4, 100, "t2_four_grants");
    st_valid = '0;
    run_until_idle(20, "t2a_done");
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_order%0d", i), 32'(gnt_log.size() > i ? gnt_log[i] : -1), 32'(t2a[i]));
    gnt_log.delete();
    st_valid = 4'b0101;
    run_until_grants(2, 100, "t2_two_grants");
    st_valid = '0;
    run_until_idle(20, "t2b_done");
    for (int i = 0; i < 2; i++)
      chk($sformatf("t2_pair%0d", i), 32'(gnt_log.size() > i ? gnt_log[i] : -1), 32'(t2b[i]));

    // response held 20+ cycles, other requesters waiting
    set_req(3, 24'hfedcba, 12'h777, MODE_AND);
    st_valid = 4'b1000; eng_delay = 2; st_rsp_ready = 1'b0;
    step();
    st_valid = 4'b0111;
    repeat (25) step();
    st_rsp_ready = 1'b1;
    step();
    st_valid = '0;
    run_until_idle(20, "t3_done");

    // stray set_valid in IDLE, and together with rsp_ready in RESP
    force_spur = 1'b1;
    repeat (5) step();
    force_spur = 1'b0;
    st_valid = 4'b0001; eng_delay = 2; st_rsp_ready = 1'b0;
    step();
    st_valid = '0;
    k = 0;
    while (!(busy && sv_done && cyc > sv_cyc) && k < 20) begin
      step();
      k++;
    end
    chk("t4_reached_resp", 32'(busy && sv_done), 1);
    st_rsp_ready = 1'b1; force_spur = 1'b1;
    step();
    force_spur = 1'b0;
    repeat (5) step();

`ifdef SET_SCHED_TIMEOUT_EN
    // engine never answers: error response 11 cycles after set_en
    n_err_obs = 0;
    eng_never = 1'b1;
    st_valid = 4'b0010;
    step();
    st_valid = '0;
    run_until_idle(30, "t6_done");
    eng_never = 1'b0;
    chk("t6_err_rsp", 32'(n_err_obs), 1);
`endif

    // randomized traffic
    spur_en = 1'b1; eng_delay = -1; eng_cand = -1;
    for (int i = 0; i < 3000; i++) begin
      for (int r = 0; r < NREQ; r++) set_req(r, 24'($urandom), 12'($urandom), 2'($urandom));
      st_valid     = (i % 400 < 200) ? NREQ'($urandom) : NREQ'($urandom) & NREQ'($urandom);
      st_rsp_ready = ($urandom_range(0, 3) != 0);
      st_rst       = ($urandom_range(0, 499) == 0);
      step();
    end
    st_rst = 1'b0; st_valid = '0; st_rsp_ready = 1'b1; spur_en = 1'b0;
    run_until_idle(40, "drain");
    chk("rsp_vs_grant", 32'(n_rsp), 32'(n_grant - n_abort));
    chk("enough_traffic", 32'(n_rsp > 100), 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
